pipeline_wb: RTL and testbench
==============================

# pipeline_wb

Writeback stage of the 5-stage RV32I pipeline, directly downstream of the MEM/WB register. It selects the writeback result, sign- or zero-extends sub-word load data, and owns the 32×32 integer register file. The register file provides two decode-stage read ports with same-cycle write bypass.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- RegWriteW  in  1  writeback enable from MEM/WB.
- ResultSrcW  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- ReadDataW  in  32  aligned data-memory word.
- ALUResultW  in  32  ALU result; bits [1:0] are the load byte offset.
- RdW  in  5  destination register.
- PC_plus4W  in  32  link value.
- InstrW  in  32  instruction in WB; the reset/bubble value is 32'h0000_0033.
- Rs1D, Rs2D  in  5 each  decode-stage source register indices.
- RD1D, RD2D  out  32 each  decode-stage operands.
- ResultW  out  32  writeback value, also used as the EX forwarding source.
- InstretW  out  64  retired-instruction count; present only with RETIRE_CNT_EN.

## Operation
Load extension is applied only when InstrW[6:0] == 7'b0000011. It uses funct3 = InstrW[14:12] and off = ALUResultW[1:0], little-endian:
- LB (000): the byte at off, sign-extended.
- LH (001): the half at off[1], sign-extended.
- LW (010): the full word.
- LBU (100): the byte at off, zero-extended.
- LHU (101): the half at off[1], zero-extended.
- Any other funct3: the full word. Misalignment is not checked.
- For non-load opcodes, the load value is ReadDataW unmodified.

Result mux:
- ResultW is the load value when ResultSrcW == 01.
- ResultW is PC_plus4W when ResultSrcW == 10.
- Otherwise ResultW is ALUResultW.

Register file write:
- At the rising edge, regs[RdW] <= ResultW when RegWriteW && RdW != 0.
- Writes to x0 are discarded.

Register file read:
- Reads are combinational.
- Rs == 0 returns 0.
- If RegWriteW && RdW != 0 && RdW == Rs, the read returns ResultW (bypass).
- Otherwise the read returns regs[Rs].
- Bypass applies independently to each port; both ports may bypass the same register.

## Timing
- Reset: all 31 registers clear to 0 asynchronously, and InstretW clears to 0.
  - While n_rst is low, RD1D and RD2D read 0 unless bypassed.
  - ResultW is always a pure combinational function of the inputs.
- Reset asserted in the same cycle as a pending write: the write is lost and the register reads 0.
- Latency: ResultW is zero-cycle combinational. A value written at edge N is readable from the array after edge N, and is visible through the bypass during cycle N-1.
- The block has no stall input. The MEM/WB register inserts bubbles as 32'h0000_0033 with RegWriteW = 0.

## Configuration
- RETIRE_CNT_EN defined:
  - A 64-bit InstretW counter is compiled in.
  - It increments by 1 at each rising edge where InstrW != 32'h0000_0033.
  - It wraps from 2^64-1 to 0.
  - It resets asynchronously to 0.
- RETIRE_CNT_EN undefined: the counter and the InstretW port are absent, and all other behaviour is identical.

## Structure
- pipeline_pkg holds:
  - the ResultSrc encoding constants (RES_ALU, RES_LOAD, RES_PC4);
  - OP_LOAD = 7'b0000011;
  - the funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - NOP_INSTR = 32'h0000_0033.
- One combinational sub-module, load_ext, takes funct3, the byte offset and the word, and produces the extended value. The register file and the retire counter stay inline.

## Test plan
- Reset, then read every Rs1D/Rs2D 0..31 -> all 0; with RETIRE_CNT_EN, InstretW = 0.
- Write x5 = 32'hDEAD_BEEF (ResultSrcW = 00, RegWriteW = 1); in the same cycle Rs1D = Rs2D = 5 -> RD1D = RD2D = 32'hDEAD_BEEF via bypass. On the next cycle with RegWriteW = 0 -> still 32'hDEAD_BEEF.
- RegWriteW = 1, RdW = 0, ALUResultW = 32'h1234 -> a subsequent Rs1D = 0 reads 0.
- Load InstrW with funct3 = 000, ReadDataW = 32'h80FF_7F01, off = 3 -> ResultW = 32'hFFFF_FF80.
  - funct3 = 100, same off -> ResultW = 32'h0000_0080.
  - funct3 = 101, off = 2 -> ResultW = 32'h0000_80FF.
- ResultSrcW = 10, PC_plus4W = 32'h0000_0104, RdW = 1 -> x1 = 32'h0000_0104 after the edge.
- RETIRE_CNT_EN: feed 4 valid instructions interleaved with 2 bubbles of 32'h0000_0033 -> InstretW = 4. Assert n_rst mid-write -> the target register reads 0 and InstretW = 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32I writeback stage: result-select codes,
// load opcode/funct3 values and the pipeline bubble instruction.
package pipeline_pkg;

    localparam logic [1:0]  RES_ALU   = 2'b00;
    localparam logic [1:0]  RES_LOAD  = 2'b01;
    localparam logic [1:0]  RES_PC4   = 2'b10;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;

    localparam logic [2:0]  F3_LB     = 3'b000;
    localparam logic [2:0]  F3_LH     = 3'b001;
    localparam logic [2:0]  F3_LW     = 3'b010;
    localparam logic [2:0]  F3_LBU    = 3'b100;
    localparam logic [2:0]  F3_LHU    = 3'b101;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

    function automatic logic is_load(input logic [31:0] instr);
        return instr[6:0] == OP_LOAD;
    endfunction

endpackage

// File: rtl/pipeline_wb_if.sv
// MEM/WB-to-writeback bundle plus the decode-stage read ports.
// InstretW exists only when RETIRE_CNT_EN is defined.
interface pipeline_wb_if #(
    parameter int XLEN = 32
);
    logic            RegWriteW;
    logic [1:0]      ResultSrcW;
    logic [XLEN-1:0] ReadDataW;
    logic [XLEN-1:0] ALUResultW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] PC_plus4W;
    logic [31:0]     InstrW;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] ResultW;
`ifdef RETIRE_CNT_EN
    logic [63:0]     InstretW;
`endif

    modport master (
        output RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PC_plus4W,
               InstrW, Rs1D, Rs2D,
        input  RD1D, RD2D, ResultW
`ifdef RETIRE_CNT_EN
        , input InstretW
`endif
    );

    modport slave (
        input  RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PC_plus4W,
               InstrW, Rs1D, Rs2D,
        output RD1D, RD2D, ResultW
`ifdef RETIRE_CNT_EN
        , output InstretW
`endif
    );

endinterface

// File: rtl/pipeline_wb_load_ext.sv
// Sub-word load extraction: picks the byte/half addressed by the low
// address bits (little-endian) and sign- or zero-extends it.
module load_ext
    import pipeline_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        unique case (funct3)
            F3_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   ext = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  ext = {24'h0, byte_sel};
            F3_LHU:  ext = {16'h0, half_sel};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/pipeline_wb.sv
// RV32I writeback stage: result mux, load extension and the 32x32 register
// file with write bypass. Define RETIRE_CNT_EN to add the InstretW counter.
module pipeline_wb
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic         clk,
    input  logic         n_rst,
    pipeline_wb_if.slave wb
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] load_ext_val;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] result;
    logic            wr_en;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    load_ext u_load_ext (
        .funct3 (wb.InstrW[14:12]),
        .off    (wb.ALUResultW[1:0]),
        .word   (wb.ReadDataW),
        .ext    (load_ext_val)
    );

    always_comb begin
        load_val = is_load(wb.InstrW) ? load_ext_val : wb.ReadDataW;
        unique case (wb.ResultSrcW)
            RES_LOAD: result = load_val;
            RES_PC4:  result = wb.PC_plus4W;
            default:  result = wb.ALUResultW;
        endcase
    end

    assign wb.ResultW = result;
    assign wr_en      = wb.RegWriteW && (wb.RdW != '0);

    // Entry 0 is held at zero so x0 can never be written.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wb.RdW[AW-1:0]] = result;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass lets decode see a value in the same cycle it is being written.
    always_comb begin
        if (wb.Rs1D == '0)                 wb.RD1D = '0;
        else if (wr_en && wb.RdW == wb.Rs1D) wb.RD1D = result;
        else                               wb.RD1D = regs_q[wb.Rs1D[AW-1:0]];

        if (wb.Rs2D == '0)                 wb.RD2D = '0;
        else if (wr_en && wb.RdW == wb.Rs2D) wb.RD2D = result;
        else                               wb.RD2D = regs_q[wb.Rs2D[AW-1:0]];
    end

`ifdef RETIRE_CNT_EN
    logic [63:0] instret_q;
    logic [63:0] instret_d;

    always_comb begin
        instret_d = instret_q;
        if (wb.InstrW != NOP_INSTR) instret_d = instret_q + 64'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) instret_q <= '0;
        else        instret_q <= instret_d;
    end

    assign wb.InstretW = instret_q;
`else
    logic unused_instr;
    assign unused_instr = ^{wb.InstrW[31:15], wb.InstrW[11:7]};
`endif

endmodule

// File: tb/tb_pipeline_wb.sv
// Directed bench for pipeline_wb with a scoreboard of expected values.
// Compile with +define+RETIRE_CNT_EN to also cover the retire counter.
module tb_pipeline_wb;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    pipeline_wb_if #(.XLEN(32)) wb ();

    pipeline_wb #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .wb    (wb)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t            sb[$];
    int              checks   = 0;
    int              failures = 0;
    longint unsigned cnt_m    = 0;

    task automatic expect_val(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_out(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        expect_val(tag, exp);
        check_out(obs);
    endtask

    // One full clock: the model counter tracks retirements at the rising edge.
    task automatic cycle();
        @(posedge clk);
        if (n_rst === 1'b1 && wb.InstrW !== NOP_INSTR) cnt_m++;
        @(negedge clk);
    endtask

    task automatic idle();
        wb.RegWriteW  = 1'b0;
        wb.ResultSrcW = RES_ALU;
        wb.ReadDataW  = 32'h0;
        wb.ALUResultW = 32'h0;
        wb.RdW        = 5'd0;
        wb.PC_plus4W  = 32'h0;
        wb.InstrW     = NOP_INSTR;
    endtask

    function automatic logic [31:0] load_instr(input logic [2:0] f3);
        return {17'h0, f3, 5'd3, OP_LOAD};
    endfunction

    task automatic write_alu(input logic [4:0] rd, input logic [31:0] v);
        wb.RegWriteW  = 1'b1;
        wb.ResultSrcW = RES_ALU;
        wb.RdW        = rd;
        wb.ALUResultW = v;
        wb.InstrW     = 32'h0000_0013;
    endtask

    task automatic check_retire(input string tag, input longint unsigned exp);
`ifdef RETIRE_CNT_EN
        chk(tag, wb.InstretW, exp);
        chk({tag, "_model"}, wb.InstretW, cnt_m);
`else
        if (exp != cnt_m) $display("note: %s model count %0d", tag, cnt_m);
`endif
    endtask

    initial begin
        idle();
        wb.Rs1D = 5'd0;
        wb.Rs2D = 5'd0;
        n_rst   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        #1;

        // Reset state of both read ports
        for (int r = 0; r < 32; r++) begin
            wb.Rs1D = 5'(r);
            wb.Rs2D = 5'(31 - r);
            #1;
            chk($sformatf("rst_rd1_x%0d", r), 64'(wb.RD1D), 64'h0);
            chk($sformatf("rst_rd2_x%0d", 31 - r), 64'(wb.RD2D), 64'h0);
        end
        check_retire("rst_instret", 0);

        // Same-cycle bypass on both ports, then read from the array
        @(negedge clk);
        write_alu(5'd5, 32'hDEAD_BEEF);
        wb.Rs1D = 5'd5;
        wb.Rs2D = 5'd5;
        #1;
        chk("bypass_rd1", 64'(wb.RD1D), 64'hDEAD_BEEF);
        chk("bypass_rd2", 64'(wb.RD2D), 64'hDEAD_BEEF);
        chk("bypass_result", 64'(wb.ResultW), 64'hDEAD_BEEF);
        cycle();
        idle();
        #1;
        chk("array_rd1_x5", 64'(wb.RD1D), 64'hDEAD_BEEF);
        chk("array_rd2_x5", 64'(wb.RD2D), 64'hDEAD_BEEF);

        // Write to x0 is discarded and never bypassed
        write_alu(5'd0, 32'h0000_1234);
        wb.Rs1D = 5'd0;
        #1;
        chk("x0_no_bypass", 64'(wb.RD1D), 64'h0);
        cycle();
        idle();
        #1;
        chk("x0_after_write", 64'(wb.RD1D), 64'h0);
        chk("x5_kept", 64'(wb.RD2D), 64'hDEAD_BEEF);

        // Load extension
        wb.ResultSrcW = RES_LOAD;
        wb.ReadDataW  = 32'h80FF_7F01;
        wb.ALUResultW = 32'h0000_0003;
        wb.InstrW     = load_instr(F3_LB);
        #1;
        chk("lb_off3", 64'(wb.ResultW), 64'hFFFF_FF80);
        wb.InstrW = load_instr(F3_LBU);
        #1;
        chk("lbu_off3", 64'(wb.ResultW), 64'h0000_0080);
        wb.ALUResultW = 32'h0000_0002;
        wb.InstrW     = load_instr(F3_LHU);
        #1;
        chk("lhu_off2", 64'(wb.ResultW), 64'h0000_80FF);
        wb.InstrW = load_instr(F3_LH);
        #1;
        chk("lh_off2", 64'(wb.ResultW), 64'hFFFF_80FF);
        wb.ALUResultW = 32'h0000_0000;
        wb.InstrW     = load_instr(F3_LB);
        #1;
        chk("lb_off0", 64'(wb.ResultW), 64'h0000_0001);
        wb.ALUResultW = 32'h0000_0001;
        #1;
        chk("lb_off1", 64'(wb.ResultW), 64'h0000_007F);
        wb.InstrW = load_instr(F3_LH);
        wb.ALUResultW = 32'h0000_0000;
        #1;
        chk("lh_off0", 64'(wb.ResultW), 64'h0000_7F01);
        wb.InstrW = load_instr(F3_LW);
        #1;
        chk("lw", 64'(wb.ResultW), 64'h80FF_7F01);
        wb.InstrW = load_instr(3'b111);
        wb.ALUResultW = 32'h0000_0003;
        #1;
        chk("ld_f3_other", 64'(wb.ResultW), 64'h80FF_7F01);
        wb.InstrW = 32'h0000_0013;
        #1;
        chk("nonload_raw", 64'(wb.ResultW), 64'h80FF_7F01);
        wb.ResultSrcW = 2'b11;
        wb.ALUResultW = 32'h0BAD_F00D;
        #1;
        chk("src11_alu", 64'(wb.ResultW), 64'h0BAD_F00D);

        // Load written back through the register file
        wb.ResultSrcW = RES_LOAD;
        wb.ALUResultW = 32'h0000_0003;
        wb.InstrW     = load_instr(F3_LB);
        wb.RegWriteW  = 1'b1;
        wb.RdW        = 5'd9;
        cycle();
        idle();
        wb.Rs1D = 5'd9;
        #1;
        chk("x9_lb", 64'(wb.RD1D), 64'hFFFF_FF80);

        // PC+4 link write
        wb.ResultSrcW = RES_PC4;
        wb.PC_plus4W  = 32'h0000_0104;
        wb.ALUResultW = 32'h5555_5555;
        wb.RdW        = 5'd1;
        wb.RegWriteW  = 1'b1;
        wb.InstrW     = 32'h0000_00EF;
        #1;
        chk("pc4_result", 64'(wb.ResultW), 64'h0000_0104);
        cycle();
        idle();
        wb.Rs1D = 5'd1;
        wb.Rs2D = 5'd9;
        #1;
        chk("x1_pc4", 64'(wb.RD1D), 64'h0000_0104);
        chk("x9_kept", 64'(wb.RD2D), 64'hFFFF_FF80);
        check_retire("instret_mid", cnt_m);

        // Fresh reset, then 4 retirements interleaved with 2 bubbles
        n_rst = 1'b0;
        cnt_m = 0;
        wb.Rs1D = 5'd5;
        #1;
        chk("async_rst_x5", 64'(wb.RD1D), 64'h0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i != 1 && i != 4) wb.InstrW = 32'h0000_0013 | (32'(i) << 20);
            cycle();
        end
        idle();
        #1;
        check_retire("instret_4", 4);

        // Reset while a write is pending: the write is lost
        write_alu(5'd7, 32'h0000_AAAA);
        cycle();
        idle();
        wb.Rs1D = 5'd7;
        #1;
        chk("x7_written", 64'(wb.RD1D), 64'h0000_AAAA);
        write_alu(5'd7, 32'h0000_5555);
        #1;
        n_rst = 1'b0;
        cnt_m = 0;
        #1;
        chk("rst_bypass_x7", 64'(wb.RD1D), 64'h0000_5555);
        cycle();
        idle();
        n_rst = 1'b1;
        #1;
        chk("x7_after_rst", 64'(wb.RD1D), 64'h0);
        check_retire("instret_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
